// File: rtl/brcomp_pkg.sv
// Shared types and helpers for the sequential branch comparator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package brcomp_pkg;

  // RISC-V funct3 encodings of the six conditional branches
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } brcomp_state_e;

  // Default geometry; instances derive their own values from XLEN/CHUNK
  localparam int XLEN_DEF   = 32;
  localparam int CHUNK_DEF  = 8;
  localparam int NCHUNK_DEF = XLEN_DEF / CHUNK_DEF;

  // Chunk index width, kept at least one bit so a single-chunk build still elaborates
  function automatic int f_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  localparam int IDX_W_DEF = f_idx_w(NCHUNK_DEF);

  // funct3 010/011 are not branches
  function automatic logic f_is_illegal(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // BLT/BGE compare two's-complement operands
  function automatic logic f_is_signed(input logic [2:0] op);
    return (op[2:1] == 2'b10);
  endfunction

  // Branch decision from the compare flags; non-branch encodings never take
  function automatic logic f_taken(input logic [2:0] op, input logic eq, input logic less);
    logic t;
    t = 1'b0;
    case (op)
      BR_BEQ:           t = eq;
      BR_BNE:           t = !eq;
      BR_BLT, BR_BLTU:  t = less;
      BR_BGE, BR_BGEU:  t = !less;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/brcomp_seq_if.sv
// Request/result bundle between issue stage, comparator and branch unit.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the result side.
interface brcomp_seq_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      br_op_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            kill_i;
  logic            valid_o;
  logic            ready_i;
  logic            br_equal_o;
  logic            br_less_o;
  logic            br_taken_o;
  logic            illegal_o;

  // Issue stage / branch unit side
  modport master (
    output valid_i, br_op_i, rs1_data_i, rs2_data_i, kill_i, ready_i,
    input  ready_o, valid_o, br_equal_o, br_less_o, br_taken_o, illegal_o
  );

  // Comparator side
  modport slave (
    input  valid_i, br_op_i, rs1_data_i, rs2_data_i, kill_i, ready_i,
    output ready_o, valid_o, br_equal_o, br_less_o, br_taken_o, illegal_o
  );
endinterface

// File: rtl/brcomp_chunk.sv
// Combinational CHUNK-bit compare; flip_msb turns the unsigned compare into a signed one.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module brcomp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] msk;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  // Inverting both sign bits maps two's complement order onto unsigned order
  always_comb begin
    msk = '0;
    msk[CHUNK-1] = flip_msb;
    a_x = a ^ msk;
    b_x = b ^ msk;
    eq  = (a == b);
    lt  = (a_x < b_x);
  end

endmodule

// File: rtl/brcomp_seq.sv
// Multi-cycle branch comparator: MSB-first, CHUNK bits per cycle, optional early exit.
// Latency: k+1 cycles counting the accept cycle (k = CMP cycles, 1..NCHUNK); illegal op 1.
// Backpressure: one request in flight; result held in DONE until ready_i; kill_i overrides all.
module brcomp_seq
  import brcomp_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  brcomp_seq_if.slave bus
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDX_W  = f_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  brcomp_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic eq_q, eq_d;
  logic less_q, less_d;
  logic taken_q, taken_d;
  logic ill_q, ill_d;
  // Set once a differing chunk has fixed the result (only matters without early exit)
  logic hit_q, hit_d;
  logic load;

  logic ch_eq, ch_lt, ch_flip;

  // Sign handling applies only to the most significant chunk
  assign ch_flip = f_is_signed(op_q) && (idx_q == IDX_TOP);

  brcomp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[idx_q]),
    .b        (b_q[idx_q]),
    .flip_msb (ch_flip),
    .eq       (ch_eq),
    .lt       (ch_lt)
  );

  // Next state, chunk walk and result accumulation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    less_d  = less_q;
    taken_d = taken_q;
    ill_d   = ill_q;
    hit_d   = hit_q;
    load    = 1'b0;

    if (bus.kill_i) begin
      state_d = IDLE;
      idx_d   = '0;
      eq_d    = 1'b0;
      less_d  = 1'b0;
      taken_d = 1'b0;
      ill_d   = 1'b0;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            load    = 1'b1;
            less_d  = 1'b0;
            taken_d = 1'b0;
            hit_d   = 1'b0;
            if (f_is_illegal(bus.br_op_i)) begin
              state_d = DONE;
              ill_d   = 1'b1;
              eq_d    = 1'b0;
            end else begin
              state_d = CMP;
              idx_d   = IDX_TOP;
              ill_d   = 1'b0;
              eq_d    = 1'b1;
            end
          end
        end
        CMP: begin
          if (!hit_q && !ch_eq) begin
            eq_d   = 1'b0;
            less_d = ch_lt;
            hit_d  = 1'b1;
          end
          if (((EARLY_EXIT != 0) && !ch_eq) || (idx_q == '0)) begin
            state_d = DONE;
            taken_d = f_taken(op_q, eq_d, less_d);
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            state_d = IDLE;
            eq_d    = 1'b0;
            less_d  = 1'b0;
            taken_d = 1'b0;
            ill_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      eq_q    <= 1'b0;
      less_q  <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      less_q  <= less_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
      hit_q   <= hit_d;
      if (load) begin
        a_q  <= bus.rs1_data_i;
        b_q  <= bus.rs2_data_i;
        op_q <= bus.br_op_i;
      end
    end
  end

  // Results are only visible in DONE; eq_q runs as an accumulator during CMP
  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = (state_q == DONE);
  assign bus.br_equal_o = bus.valid_o & eq_q;
  assign bus.br_less_o  = bus.valid_o & less_q;
  assign bus.br_taken_o = bus.valid_o & taken_q;
  assign bus.illegal_o  = bus.valid_o & ill_q;

endmodule

// File: tb/tb_brcomp_seq.sv
// Directed bench for brcomp_seq: three builds (32/8 early exit, 32/8 full walk, 64/16 early exit).
// Latency: measured in cycles from the accept cycle to valid_o.
// Backpressure: exercised through ready_i holds and kill_i.
module tb_brcomp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        kill = 1'b0;
  logic        rdy_in = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  brcomp_seq_if #(.XLEN(32)) if0 ();
  brcomp_seq_if #(.XLEN(32)) if1 ();
  brcomp_seq_if #(.XLEN(64)) if2 ();

  assign if0.valid_i = valid;  assign if1.valid_i = valid;  assign if2.valid_i = valid;
  assign if0.br_op_i = op;     assign if1.br_op_i = op;     assign if2.br_op_i = op;
  assign if0.kill_i  = kill;   assign if1.kill_i  = kill;   assign if2.kill_i  = kill;
  assign if0.ready_i = rdy_in; assign if1.ready_i = rdy_in; assign if2.ready_i = rdy_in;
  assign if0.rs1_data_i = a[31:0]; assign if0.rs2_data_i = b[31:0];
  assign if1.rs1_data_i = a[31:0]; assign if1.rs2_data_i = b[31:0];
  assign if2.rs1_data_i = a;       assign if2.rs2_data_i = b;

  brcomp_seq #(.XLEN(32), .CHUNK(8),  .EARLY_EXIT(1)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  brcomp_seq #(.XLEN(32), .CHUNK(8),  .EARLY_EXIT(0)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  brcomp_seq #(.XLEN(64), .CHUNK(16), .EARLY_EXIT(1)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic        eq;
    logic        less;
    logic        taken;
    logic        ill;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic r, output logic e,
                        output logic l, output logic t, output logic il);
    case (sel)
      0: begin v = if0.valid_o; r = if0.ready_o; e = if0.br_equal_o;
               l = if0.br_less_o; t = if0.br_taken_o; il = if0.illegal_o; end
      1: begin v = if1.valid_o; r = if1.ready_o; e = if1.br_equal_o;
               l = if1.br_less_o; t = if1.br_taken_o; il = if1.illegal_o; end
      default: begin v = if2.valid_o; r = if2.ready_o; e = if2.br_equal_o;
               l = if2.br_less_o; t = if2.br_taken_o; il = if2.illegal_o; end
    endcase
  endtask

  // Issue one request (all builds see it) and wait for the selected build's result
  task automatic run_req(input int sel, input logic [2:0] o, input logic [63:0] aa,
                         input logic [63:0] bb, output int lat, output logic e,
                         output logic l, output logic t, output logic il);
    logic v, r;
    valid = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    sample(sel, v, r, e, l, t, il);
    while (!v && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(sel, v, r, e, l, t, il);
    end
  endtask

  // Consume every pending result and return all builds to IDLE
  task automatic drain(input string name);
    int n;
    n = 0;
    rdy_in = 1'b1;
    @(posedge clk); #1;
    while (!(if0.ready_o && if1.ready_o && if2.ready_o) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    rdy_in = 1'b0;
    chk(name, {61'b0, if0.ready_o, if1.ready_o, if2.ready_o}, 64'h7);
  endtask

  initial begin : main
    int lat;
    logic v, r, e, l, t, il;
    logic seen;

    //          sel op      a                       b                       lat eq less tk ill
    vec[0]  = '{0, 3'b100, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2, 0, 1, 1, 0};
    vec[1]  = '{0, 3'b110, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2, 0, 0, 0, 0};
    vec[2]  = '{0, 3'b111, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2, 0, 0, 1, 0};
    vec[3]  = '{0, 3'b001, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0001, 5, 0, 1, 1, 0};
    vec[4]  = '{1, 3'b001, 64'h0000_0000_0100_0000, 64'h0000_0000_0000_0000, 5, 0, 0, 1, 0};
    vec[5]  = '{2, 3'b101, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 5, 1, 0, 1, 0};
    vec[6]  = '{0, 3'b010, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 1, 0, 0, 0, 1};
    vec[7]  = '{0, 3'b011, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1, 0, 0, 0, 1};
    vec[8]  = '{0, 3'b000, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678, 5, 1, 0, 1, 0};
    vec[9]  = '{0, 3'b101, 64'h0000_0000_8000_0000, 64'h0000_0000_7FFF_FFFF, 2, 0, 1, 0, 0};
    vec[10] = '{1, 3'b100, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 5, 0, 1, 1, 0};
    vec[11] = '{2, 3'b110, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 5, 0, 1, 1, 0};
    vec[12] = '{0, 3'b000, 64'h0000_0000_00FF_0000, 64'h0000_0000_00FE_0000, 3, 0, 0, 0, 0};
    vec[13] = '{1, 3'b000, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678, 5, 1, 0, 1, 0};

    // Reset state
    #12;
    for (int s = 0; s < 3; s++) begin
      sample(s, v, r, e, l, t, il);
      chk($sformatf("rst%0d_outs", s), {58'b0, v, r, e, l, t, il}, 64'h10);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      run_req(vec[i].sel, vec[i].op, vec[i].a, vec[i].b, lat, e, l, t, il);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vec[i].lat));
      chk($sformatf("v%0d_eq", i), {63'b0, e}, {63'b0, vec[i].eq});
      chk($sformatf("v%0d_less", i), {63'b0, l}, {63'b0, vec[i].less});
      chk($sformatf("v%0d_taken", i), {63'b0, t}, {63'b0, vec[i].taken});
      chk($sformatf("v%0d_ill", i), {63'b0, il}, {63'b0, vec[i].ill});
      drain($sformatf("v%0d_drain", i));
    end

    // Asynchronous reset during the second CMP cycle, then rerun
    valid = 1'b1; op = 3'b000; a = 64'h1234_5678; b = 64'h1234_5678;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy", {63'b0, if0.ready_o}, 64'h0);
    rst_n = 1'b0;
    #1;
    sample(0, v, r, e, l, t, il);
    chk("rstmid_outs", {58'b0, v, r, e, l, t, il}, 64'h10);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(0, 3'b000, 64'h1234_5678, 64'h1234_5678, lat, e, l, t, il);
    chk("rstmid_lat", 64'(lat), 64'd5);
    chk("rstmid_eq_taken", {62'b0, e, t}, 64'h3);
    drain("rstmid_drain");

    // Backpressure hold, then a back-to-back request accepted only once IDLE
    valid = 1'b1; op = 3'b100; a = 64'hFFFF_FFFF; b = 64'h1;
    @(posedge clk); #1;
    op = 3'b110;
    @(posedge clk); #1;
    sample(0, v, r, e, l, t, il);
    chk("bp_first", {58'b0, v, r, e, l, t, il}, 64'h26);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sample(0, v, r, e, l, t, il);
      chk($sformatf("bp_hold%0d", k), {58'b0, v, r, e, l, t, il}, 64'h26);
    end
    rdy_in = 1'b1;
    @(posedge clk); #1;
    rdy_in = 1'b0;
    chk("bp_release_idle", {62'b0, if0.valid_o, if0.ready_o}, 64'h1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("bp_b2b_accept", {63'b0, if0.ready_o}, 64'h0);
    @(posedge clk); #1;
    sample(0, v, r, e, l, t, il);
    chk("bp_b2b_result", {58'b0, v, r, e, l, t, il}, 64'h20);
    drain("bp_drain");

    // Kill during CMP: no result, IDLE next cycle
    valid = 1'b1; op = 3'b000; a = 64'h1234_5678; b = 64'h1234_5678;
    @(posedge clk); #1;
    valid = 1'b0; kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("killcmp_idle", {62'b0, if0.valid_o, if0.ready_o}, 64'h1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen = seen | if0.valid_o | if1.valid_o | if2.valid_o;
    end
    chk("killcmp_noresult", {63'b0, seen}, 64'h0);

    // Kill in DONE together with ready_i: result dropped
    valid = 1'b1; op = 3'b010; a = '0; b = '0;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("killdone_pre", {62'b0, if0.valid_o, if0.illegal_o}, 64'h3);
    kill = 1'b1; rdy_in = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; rdy_in = 1'b0;
    sample(0, v, r, e, l, t, il);
    chk("killdone_post", {58'b0, v, r, e, l, t, il}, 64'h10);

    // Kill together with valid_i in IDLE: request ignored
    valid = 1'b1; kill = 1'b1; op = 3'b000; a = 64'h5; b = 64'h5;
    @(posedge clk); #1;
    valid = 1'b0; kill = 1'b0;
    chk("killidle_notaccepted", {63'b0, if0.ready_o}, 64'h1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen = seen | if0.valid_o | if1.valid_o | if2.valid_o;
    end
    chk("killidle_noresult", {63'b0, seen}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
